ram_arbiter: RTL
================

Name: ram_arbiter

Overview:
- Shares the single-read-port / word-write data RAM (`ram`) between two requesters:
  - the instruction-fetch unit (IF), read-only;
  - the load/store unit (LS), reads and byte/half/word stores.
- Arbitrates between them and registers read data with one-cycle latency.
- Implements sub-word stores as a two-cycle read-modify-write (RMW), because the RAM writes whole words only.
- Sits between the pipeline IF/MEM stages and the `ram` instance.

Parameters:
- ADDR_WIDTH, 32, byte-address width.
- DATA_WIDTH, 32, word width; fixed at 32, byte lanes assume 4 bytes.
- ADDR_DEPTH, 4096, RAM depth in words; valid word index is addr[31:2] < ADDR_DEPTH.
- STARVE_MAX, 4, consecutive IF denials after which IF wins over LS.

Ports:
- clk_100MHz  in  1  system clock; all state updates on its rising edge.
- arst_n  in  1  asynchronous active-low reset.
- if_req_i  in  1  IF read request.
- if_addr_i  in  ADDR_WIDTH  IF byte address; word aligned.
- if_gnt_o  out  1  IF request accepted this cycle.
- if_rvalid_o  out  1  IF read data valid; one-cycle pulse.
- if_rdata_o  out  DATA_WIDTH  IF read word.
- ls_req_i  in  1  LS request.
- ls_we_i  in  1  1 = store, 0 = load.
- ls_size_i  in  2  00 byte, 01 half, 10 word, 11 reserved.
- ls_addr_i  in  ADDR_WIDTH  LS byte address.
- ls_wdata_i  in  DATA_WIDTH  store data, right-aligned (byte in [7:0], half in [15:0]).
- ls_gnt_o  out  1  LS request accepted this cycle.
- ls_rvalid_o  out  1  LS completion pulse, for loads and stores.
- ls_rdata_o  out  DATA_WIDTH  full aligned word for loads; 0 for stores and errors.
- ls_err_o  out  1  valid with ls_rvalid_o; misaligned, reserved size, or out of range.
- ram_rena_o  out  1  RAM read enable.
- ram_raddr_o  out  ADDR_WIDTH  RAM read address.
- ram_rdata_i  in  DATA_WIDTH  RAM combinational read data.
- ram_wena_o  out  1  RAM write enable.
- ram_waddr_o  out  ADDR_WIDTH  RAM write address.
- ram_wdata_i is not used; ram_wdata_o  out  DATA_WIDTH  RAM write data.

Behaviour:
- Reset (arst_n = 0, asynchronous):
  - state IDLE, starve counter 0;
  - all outputs 0: rvalid, err, rdata registers, gnt, RAM enables, addresses and write data;
  - an in-flight RMW is discarded and no RAM write occurs.
- States: IDLE, RMW_WR.
- Grant logic, IDLE only, combinational in the request cycle:
  - LS wins when both request, unless starve_cnt == STARVE_MAX, in which case IF wins.
  - starve_cnt increments when if_req_i is high and IF is not granted, saturating at STARVE_MAX.
  - starve_cnt clears on any IF grant or when if_req_i is low.
  - At most one gnt per cycle.
- Granted read (IF read, or LS load):
  - ram_rena_o = 1 and ram_raddr_o = request address in the same cycle.
  - ram_rdata_i is captured at the rising edge.
  - The requester's rvalid and rdata are presented the next cycle for exactly one cycle.
  - LS loads return the whole aligned word; the LSU performs lane select and extension.
- Granted word store:
  - ram_wena_o, ram_waddr_o and ram_wdata_o = ls_wdata_i are driven in the grant cycle; the RAM writes at that edge.
  - ls_rvalid_o pulses the next cycle with ls_err_o = 0.
- Granted byte/half store:
  - Grant cycle: RAM read of the aligned word; merged word registered.
  - Merge uses little-endian lane addr[1:0]: byte replaces bits [8*a+7 : 8*a]; half replaces [16*a[1]+15 : 16*a[1]].
  - Next state RMW_WR.
  - RMW_WR cycle: ram_wena_o = 1 with the registered address and merged word; both gnt forced to 0; return to IDLE.
  - ls_rvalid_o pulses the cycle after RMW_WR.
- Errors:
  - Conditions: half with addr[0] = 1; word with addr[1:0] != 0; size 11; addr[31:2] >= ADDR_DEPTH.
  - Response: granted, no RAM enable asserted, ls_rvalid_o and ls_err_o pulse the next cycle.
  - IF misalignment or out-of-range is never reported; IF ignores addr[1:0] and out-of-range data is undefined.
- Hazards:
  - A read issued the cycle after a write returns the newly written word (RAM read is combinational after the write edge).
  - No ordering buffer is needed, because responses are in order per requester.
- Requesters hold req and all request fields until they see gnt.

Decomposition:
- Package ram_arb_pkg:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - state enum {IDLE, RMW_WR};
  - ADDR_DEPTH default.
- One combinational sub-module, ram_store_merge:
  - inputs: old word, ls_wdata_i, addr[1:0], size;
  - output: merged word.
  - Reused by any future store path.

Test Plan:
- IF-only read: write 0xDEADBEEF at 0x10, then if_req at 0x10 → if_gnt same cycle; if_rvalid = 1 with if_rdata = 0xDEADBEEF exactly one cycle later.
- Sub-word RMW:
  - word 0x11223344 at 0x20; sb 0xAA at 0x21 → RMW_WR cycle with gnts low; then load 0x20 returns 0x1122AA44.
  - sh 0xBEEF at 0x22 → 0xBEEFAA44.
- Contention/starvation: ls_req and if_req held high continuously, STARVE_MAX = 4 → LS granted 4 cycles, IF granted on the 5th, pattern repeats.
- Errors:
  - sw at 0x06 → ls_gnt, ram_wena_o never high, ls_rvalid = 1 with ls_err_o = 1 next cycle.
  - lw at 0x4000 (index 4096) → ls_err_o = 1.
- Reset mid-RMW: assert arst_n = 0 during RMW_WR of sb 0xFF at 0x30 (old 0) → no write; after release, load 0x30 returns 0; all outputs 0 during reset.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared encodings and defaults for the RAM arbiter and store path
package ram_arb_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam int ADDR_DEPTH_DEF = 4096;
  typedef enum logic {IDLE, RMW_WR} state_t;
endpackage

// File: rtl/ram_store_merge.sv
// ram_store_merge: overlays right-aligned store data onto an old word at its little-endian lane
module ram_store_merge
  import ram_arb_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  output logic [31:0] merged
);
  // byte lanes select by addr[1:0], half lanes by addr[1]; anything else is a whole word
  always_comb begin
    merged = old_word;
    if (size == SZ_BYTE) merged[{lane, 3'b000} +: 8] = wdata[7:0];
    else if (size == SZ_HALF) merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
    else merged = wdata;
  end
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one RAM between instruction fetch and load/store, with RMW sub-word stores
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_DEPTH = ADDR_DEPTH_DEF,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk_100MHz,
  input  logic                  arst_n,
  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  output logic                  if_gnt_o,
  output logic                  if_rvalid_o,
  output logic [DATA_WIDTH-1:0] if_rdata_o,
  input  logic                  ls_req_i,
  input  logic                  ls_we_i,
  input  logic [1:0]            ls_size_i,
  input  logic [ADDR_WIDTH-1:0] ls_addr_i,
  input  logic [DATA_WIDTH-1:0] ls_wdata_i,
  output logic                  ls_gnt_o,
  output logic                  ls_rvalid_o,
  output logic [DATA_WIDTH-1:0] ls_rdata_o,
  output logic                  ls_err_o,
  output logic                  ram_rena_o,
  output logic [ADDR_WIDTH-1:0] ram_raddr_o,
  input  logic [DATA_WIDTH-1:0] ram_rdata_i,
  output logic                  ram_wena_o,
  output logic [ADDR_WIDTH-1:0] ram_waddr_o,
  output logic [DATA_WIDTH-1:0] ram_wdata_o
);
  localparam int CW = $clog2(STARVE_MAX + 1);
  state_t                state;
  logic [CW-1:0]         starve_cnt;
  logic [ADDR_WIDTH-1:0] rmw_addr;
  logic [DATA_WIDTH-1:0] rmw_data, merged;
  logic idle, rmw, if_pri, ls_bad, ls_ok, ls_load, ls_wst, ls_sst;
  ram_store_merge u_merge (
    .old_word(ram_rdata_i),
    .wdata(ls_wdata_i),
    .lane(ls_addr_i[1:0]),
    .size(ls_size_i),
    .merged(merged)
  );
  // grant and RAM control are combinational in the request cycle and held low during reset
  always_comb begin
    idle        = arst_n && state == IDLE;
    rmw         = arst_n && state == RMW_WR;
    if_pri      = starve_cnt == CW'(STARVE_MAX);
    ls_bad      = ls_size_i == 2'b11 || (ls_size_i == SZ_HALF && ls_addr_i[0]) ||
                  (ls_size_i == SZ_WORD && ls_addr_i[1:0] != 2'b00) ||
                  ls_addr_i[ADDR_WIDTH-1:2] >= (ADDR_WIDTH-2)'(ADDR_DEPTH);
    if_gnt_o    = idle && if_req_i && (!ls_req_i || if_pri);
    ls_gnt_o    = idle && ls_req_i && !(if_req_i && if_pri);
    ls_ok       = ls_gnt_o && !ls_bad;
    ls_load     = ls_ok && !ls_we_i;
    ls_wst      = ls_ok && ls_we_i && ls_size_i == SZ_WORD;
    ls_sst      = ls_ok && ls_we_i && ls_size_i != SZ_WORD;
    ram_rena_o  = if_gnt_o || ls_load || ls_sst;
    ram_raddr_o = if_gnt_o ? if_addr_i : (ls_load || ls_sst) ? ls_addr_i : '0;
    ram_wena_o  = ls_wst || rmw;
    ram_waddr_o = rmw ? rmw_addr : ls_wst ? ls_addr_i : '0;
    ram_wdata_o = rmw ? rmw_data : ls_wst ? ls_wdata_i : '0;
  end
  // FSM, starvation counter, RMW holding registers and one-cycle response pulses
  always_ff @(posedge clk_100MHz or negedge arst_n) begin
    if (!arst_n) begin
      state       <= IDLE;
      starve_cnt  <= '0;
      rmw_addr    <= '0;
      rmw_data    <= '0;
      if_rvalid_o <= 1'b0;
      if_rdata_o  <= '0;
      ls_rvalid_o <= 1'b0;
      ls_err_o    <= 1'b0;
      ls_rdata_o  <= '0;
    end else begin
      state       <= ls_sst ? RMW_WR : IDLE;
      starve_cnt  <= (!if_req_i || if_gnt_o) ? '0 : if_pri ? starve_cnt : starve_cnt + 1'b1;
      if (ls_sst) begin
        rmw_addr <= ls_addr_i;
        rmw_data <= merged;
      end
      if_rvalid_o <= if_gnt_o;
      if (if_gnt_o) if_rdata_o <= ram_rdata_i;
      ls_rvalid_o <= (ls_gnt_o && !ls_sst) || rmw;
      ls_err_o    <= ls_gnt_o && ls_bad;
      ls_rdata_o  <= ls_load ? ram_rdata_i : '0;
    end
  end
endmodule
